// File: rtl/cla_multicycle_addsub.sv
// ---------------------------------------------------------------------------
// cla_multicycle_addsub
//
// Multi-cycle add/subtract unit. An N-bit operation is resolved CHUNK bits
// per clock through one shared CHUNK-bit carry-lookahead slice, starting at
// the least significant chunk. The carry out of each chunk is registered and
// fed into the next chunk on the following cycle.
//
// Latency: start accepted at edge T -> busy in cycles T+1..T+NC -> done in
// cycle T+NC+1 (NC = N/CHUNK). Results hold until the next accepted start.
//
// Parameters:
//   N      operand/result width (default 16)
//   CHUNK  bits resolved per cycle, N % CHUNK == 0, 1 <= CHUNK <= N
//
// Ports:
//   clk    clock, all state changes on the rising edge
//   rst    synchronous active-high reset, highest priority
//   start  operation request, honoured only in IDLE or DONE
//   sub    0: a + b + c_in, 1: a + ~b + 1 (c_in ignored)
//   c_in   carry-in for add mode
//   a, b   operands, captured when start is accepted
//   busy   high while chunks are being computed
//   done   one-cycle pulse; results valid from this cycle onwards
//   sum    N-bit result (wraps modulo 2^N)
//   c_out  carry out of bit N-1 (in sub mode: 1 = no borrow)
//   ovf    two's-complement overflow
//   zero   sum == 0
// ---------------------------------------------------------------------------
module cla_multicycle_addsub #(
  parameter int N     = 16,
  parameter int CHUNK = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sub,
  input  logic         c_in,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         c_out,
  output logic         ovf,
  output logic         zero
);

  localparam int NC = N / CHUNK;
  // Chunk index width; a single-chunk configuration still keeps a 1-bit index.
  localparam int KW = (NC > 1) ? $clog2(NC) : 1;
  localparam logic [KW-1:0] K_LAST     = KW'(NC - 1);
  localparam logic [N-1:0]  CHUNK_MASK = N'({CHUNK{1'b1}});

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q;
  logic [N-1:0]  a_q;
  logic [N-1:0]  bp_q;      // B' : b, or ~b in subtract mode
  logic [N-1:0]  sum_q;
  logic [KW-1:0] k_q;
  logic          carry_q;   // carry into the current chunk
  logic          busy_q;
  logic          done_q;
  logic          c_out_q;
  logic          ovf_q;
  logic          zero_q;

  // -------------------------------------------------------------------------
  // Shared CLA slice operating on chunk k_q
  // -------------------------------------------------------------------------
  logic [31:0]      base_d;
  logic [N-1:0]     a_shift_d;
  logic [N-1:0]     b_shift_d;
  logic [CHUNK-1:0] a_chunk_d;
  logic [CHUNK-1:0] b_chunk_d;
  logic [CHUNK-1:0] g_d;
  logic [CHUNK-1:0] p_d;
  logic [CHUNK-1:0] s_chunk_d;
  logic [CHUNK:0]   c_d;
  logic [N-1:0]     sum_d;
  logic             ovf_d;
  logic             zero_d;

  // Chunks are selected by shifting rather than a variable part-select so
  // the index width stays independent of N and CHUNK.
  assign base_d    = 32'(k_q) * CHUNK;
  assign a_shift_d = a_q >> base_d;
  assign b_shift_d = bp_q >> base_d;
  assign a_chunk_d = a_shift_d[CHUNK-1:0];
  assign b_chunk_d = b_shift_d[CHUNK-1:0];

  assign g_d    = a_chunk_d & b_chunk_d;
  assign p_d    = a_chunk_d | b_chunk_d;
  assign c_d[0] = carry_q;

  for (genvar gi = 0; gi < CHUNK; gi++) begin : g_cla
    assign c_d[gi+1]     = g_d[gi] | (p_d[gi] & c_d[gi]);
    assign s_chunk_d[gi] = a_chunk_d[gi] ^ b_chunk_d[gi] ^ c_d[gi];
  end

  // Merge the freshly computed chunk into the running sum.
  assign sum_d = (sum_q & ~(CHUNK_MASK << base_d)) | (N'(s_chunk_d) << base_d);

  // Flags evaluated on the complete sum while the last chunk is written.
  assign ovf_d  = (a_q[N-1] == bp_q[N-1]) && (sum_d[N-1] != a_q[N-1]);
  assign zero_d = (sum_d == '0);

  // -------------------------------------------------------------------------
  // Control FSM with registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      bp_q    <= '0;
      sum_q   <= '0;
      k_q     <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            bp_q    <= sub ? ~b : b;
            carry_q <= sub ? 1'b1 : c_in;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            k_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end else begin
            state_q <= S_IDLE;
          end
        end

        S_RUN: begin
          sum_q   <= sum_d;
          carry_q <= c_d[CHUNK];
          k_q     <= k_q + 1'b1;
          if (k_q == K_LAST) begin
            k_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            c_out_q <= c_d[CHUNK];
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            state_q <= S_DONE;
          end
        end

        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign sum   = sum_q;
  assign c_out = c_out_q;
  assign ovf   = ovf_q;
  assign zero  = zero_q;

endmodule

// File: tb/tb_cla_multicycle_addsub.sv
`timescale 1ns/1ps
// Testbench for cla_multicycle_addsub. Four instances with different (N,CHUNK)
// run in parallel; each has a driver pushing expected results into a queue and
// a monitor that checks handshake timing and results every cycle.
module tb_cla_multicycle_addsub;

  localparam int NCFG = 4;

  function automatic int cfg_n(input int i);
    case (i)
      3:       return 32;
      default: return 16;
    endcase
  endfunction

  function automatic int cfg_c(input int i);
    case (i)
      0:       return 4;
      1:       return 16;
      2:       return 1;
      default: return 8;
    endcase
  endfunction

  typedef struct {
    logic [31:0] sum;
    logic        c_out;
    logic        ovf;
    logic        zero;
    int          t;      // cycle in which start was presented
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input int cfg,
                       input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s cfg%0d cyc=%0d: got 0x%0h expected 0x%0h",
               name, cfg, cyc, act, expv);
    end
  endtask

  // Reference model: plain integer arithmetic on unsigned and signed values.
  function automatic exp_t model(input int n, input logic [31:0] av,
                                 input logic [31:0] bv, input logic sv,
                                 input logic cv, input int t);
    exp_t   r;
    longint modv;
    longint ua, ub, sa, sb, res, sres;
    modv = longint'(1) << n;
    ua   = longint'(av);
    ub   = longint'(bv);
    sa   = (ua >= modv / 2) ? ua - modv : ua;
    sb   = (ub >= modv / 2) ? ub - modv : ub;
    if (sv) begin
      res     = ua - ub;
      sres    = sa - sb;
      r.c_out = (ua >= ub);
    end else begin
      res     = ua + ub + longint'(cv);
      sres    = sa + sb + longint'(cv);
      r.c_out = (res >= modv);
    end
    res    = ((res % modv) + modv) % modv;
    r.sum  = 32'(res);
    r.ovf  = (sres >= modv / 2) || (sres < -(modv / 2));
    r.zero = (res == 0);
    r.t    = t;
    return r;
  endfunction

  for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
    localparam int NN   = cfg_n(gi);
    localparam int CC   = cfg_c(gi);
    localparam int NCH  = NN / CC;
    localparam int NOPS = (gi == 0) ? 300 : 2000;
    localparam logic [31:0] MASK = (NN == 32) ? 32'hFFFF_FFFF : ((32'd1 << NN) - 32'd1);

    logic          rst   = 1'b1;
    logic          start = 1'b0;
    logic          sub   = 1'b0;
    logic          c_in  = 1'b0;
    logic [NN-1:0] a     = '0;
    logic [NN-1:0] b     = '0;
    logic          busy, done, c_out, ovf, zero;
    logic [NN-1:0] sum;
    logic          fin   = 1'b0;

    exp_t q[$];
    exp_t last;
    logic have_last = 1'b0;

    cla_multicycle_addsub #(.N(NN), .CHUNK(CC)) u_dut (
      .clk  (clk),
      .rst  (rst),
      .start(start),
      .sub  (sub),
      .c_in (c_in),
      .a    (a),
      .b    (b),
      .busy (busy),
      .done (done),
      .sum  (sum),
      .c_out(c_out),
      .ovf  (ovf),
      .zero (zero)
    );

    // ---------------- monitor ----------------
    always @(negedge clk) begin : mon
      logic eb, ed;
      eb = 1'b0;
      ed = 1'b0;
      if (q.size() > 0) begin
        eb = (cyc >= q[0].t + 1) && (cyc <= q[0].t + NCH);
        ed = (cyc == q[0].t + NCH + 1);
      end
      check("busy", gi, 32'(busy), 32'(eb));
      check("done", gi, 32'(done), 32'(ed));
      check("busy_and_done", gi, 32'(busy & done), 32'd0);
      if (ed) begin
        last = q.pop_front();
        have_last = 1'b1;
        $display("cfg%0d cyc=%0d result sum=0x%0h c_out=%0b ovf=%0b zero=%0b",
                 gi, cyc, sum, c_out, ovf, zero);
      end
      // Results must be valid on done and hold until the next start is taken.
      if (have_last && (q.size() == 0 || cyc <= q[0].t)) begin
        check("sum",   gi, 32'(sum),   last.sum);
        check("c_out", gi, 32'(c_out), 32'(last.c_out));
        check("ovf",   gi, 32'(ovf),   32'(last.ovf));
        check("zero",  gi, 32'(zero),  32'(last.zero));
      end
      if (rst) begin
        q.delete();
        last = '{sum: 32'd0, c_out: 1'b0, ovf: 1'b0, zero: 1'b0, t: 0};
        have_last = 1'b1;
      end
    end

    // ---------------- driver ----------------
    task automatic step();
      @(posedge clk);
      #1;
    endtask

    function automatic logic [31:0] rnd();
      case ($urandom_range(0, 7))
        0:       return 32'd0;
        1:       return MASK;
        2:       return MASK >> 1;
        3:       return (MASK >> 1) + 32'd1;
        4:       return 32'd1;
        default: return $urandom() & MASK;
      endcase
    endfunction

    task automatic issue(input logic [31:0] av, input logic [31:0] bv,
                         input logic sv, input logic cv);
      a     = NN'(av);
      b     = NN'(bv);
      sub   = sv;
      c_in  = cv;
      start = 1'b1;
      q.push_back(model(NN, av & MASK, bv & MASK, sv, cv, cyc));
      $display("cfg%0d cyc=%0d start a=0x%0h b=0x%0h sub=%0b c_in=%0b",
               gi, cyc, av & MASK, bv & MASK, sv, cv);
    endtask

    // Wait (bounded) for done; optionally wiggle inputs while busy.
    task automatic wait_done(input logic junk);
      logic found;
      found = 1'b0;
      for (int k = 0; k < NCH + 6; k++) begin
        step();
        if (done) begin
          found = 1'b1;
          break;
        end
        if (junk) begin
          a     = NN'($urandom());
          b     = NN'($urandom());
          sub   = 1'($urandom());
          c_in  = 1'($urandom());
          start = 1'($urandom());
        end
      end
      start = 1'b0;
      if (!found) check("done_timeout", gi, 32'(done), 32'd1);
    endtask

    task automatic run_op(input logic [31:0] av, input logic [31:0] bv,
                          input logic sv, input logic cv, input logic junk);
      issue(av, bv, sv, cv);
      step();
      start = 1'b0;
      wait_done(junk);
    endtask

    initial begin : drv
      logic [31:0] av, bv;
      rst = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      step();
      if (gi == 0) begin
        // Directed vectors, issued back-to-back in each done cycle.
        run_op(32'h1234, 32'h1111, 1'b0, 1'b1, 1'b0);
        run_op(32'h7FFF, 32'h0001, 1'b0, 1'b0, 1'b0);
        run_op(32'hFFFF, 32'h0001, 1'b0, 1'b0, 1'b0);
        run_op(32'h0005, 32'h0005, 1'b1, 1'b1, 1'b0);
        run_op(32'h0003, 32'h0005, 1'b1, 1'b0, 1'b0);
        run_op(32'h8000, 32'h0001, 1'b1, 1'b0, 1'b0);
        // Hold across idle cycles.
        repeat (10) step();
        // Second start at T+2 must be ignored.
        issue(32'h00FF, 32'h0F0F, 1'b0, 1'b0);
        step();
        start = 1'b0;
        step();
        a = 16'hAAAA; b = 16'h5555; sub = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        wait_done(1'b0);
        step();
        // Reset in the middle of an operation.
        issue(32'h1111, 32'h2222, 1'b0, 1'b0);
        step();
        start = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (3) step();
        run_op(32'h4321, 32'h1234, 1'b1, 1'b0, 1'b0);
        step();
      end
      for (int i = 0; i < NOPS; i++) begin
        av = rnd();
        bv = rnd();
        run_op(av, bv, 1'($urandom()), 1'($urandom()), ($urandom_range(0, 3) == 0));
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) step();
      end
      repeat (3) step();
      fin = 1'b1;
    end
  end

  initial begin : top
    int   waited;
    logic all_fin;
    waited  = 0;
    all_fin = 1'b0;
    while (!all_fin && waited < 90000) begin
      @(posedge clk);
      waited++;
      all_fin = g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin && g_cfg[3].fin;
    end
    if (!all_fin) check("global_timeout", -1, 32'(all_fin), 32'd1);
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
